// File: rtl/skid_reg_pkg.sv
// Shared definitions for the skid_reg pipeline register: occupancy state
// encoding and the naming of the two handshake transfers.
package skid_reg_pkg;

    typedef enum logic [1:0] {
        SKR_EMPTY = 2'd0,
        SKR_ONE   = 2'd1,
        SKR_FULL  = 2'd2
    } skr_state_e;

    typedef struct packed {
        logic in_fire;
        logic out_fire;
    } skr_xfer_t;

    function automatic skr_xfer_t skr_xfer(input logic in_valid,
                                           input logic in_ready,
                                           input logic out_valid,
                                           input logic out_ready);
        skr_xfer_t x;
        x.in_fire  = in_valid & in_ready;
        x.out_fire = out_valid & out_ready;
        return x;
    endfunction

endpackage

// File: rtl/skid_reg_if.sv
// Producer and consumer handshake bundle for skid_reg. The slave modport is
// the register's view; master is the view of whatever drives it.
interface skid_reg_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] Ds;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Qs;
    logic [1:0]       count;

    modport slave (
        input  in_valid, Ds, out_ready,
        output in_ready, out_valid, Qs, count
    );

    modport master (
        output in_valid, Ds, out_ready,
        input  in_ready, out_valid, Qs, count
    );
endinterface

// File: rtl/skid_reg_ld_reg.sv
// WIDTH-bit load-enable register with synchronous reset to RESET_VAL; the
// generic form of the fixed-purpose instruction/address/data registers.
module ld_reg #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] data_q;

    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge CLK) begin
        if (RST) begin
            data_q <= RESET_VAL;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;
endmodule

// File: rtl/skid_reg.sv
// Valid/ready pipeline register with a 2-entry skid buffer: main drives Qs,
// skid catches the word accepted while the consumer stalls.
module skid_reg
    import skid_reg_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       FLUSH,
    skid_reg_if.slave  bus
);
    skr_state_e       state_q, state_d;
    skr_xfer_t        xfer;
    logic             in_ready, out_valid;
    logic             main_en, skid_en;
    logic [WIDTH-1:0] main_d, main_q, skid_q;

    assign xfer = skr_xfer(bus.in_valid, in_ready, out_valid, bus.out_ready);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= SKR_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        if (FLUSH) begin
            state_d = SKR_EMPTY;
        end else begin
            case (state_q)
                SKR_EMPTY: if (xfer.in_fire) state_d = SKR_ONE;
                SKR_ONE: begin
                    if (xfer.in_fire && !xfer.out_fire) state_d = SKR_FULL;
                    else if (xfer.out_fire && !xfer.in_fire) state_d = SKR_EMPTY;
                end
                SKR_FULL: if (xfer.out_fire) state_d = SKR_ONE;
                default: state_d = SKR_EMPTY;
            endcase
        end
    end

    // in_ready deliberately ignores out_ready so no combinational path crosses the block.
    always_comb begin
        in_ready  = (state_q != SKR_FULL) && !FLUSH && !RST;
        out_valid = (state_q != SKR_EMPTY);
        main_en   = 1'b0;
        skid_en   = 1'b0;
        main_d    = bus.Ds;
        case (state_q)
            SKR_EMPTY: main_en = xfer.in_fire;
            SKR_ONE: begin
                main_en = xfer.in_fire && xfer.out_fire;
                skid_en = xfer.in_fire && !xfer.out_fire;
            end
            SKR_FULL: begin
                main_d  = skid_q;
                main_en = xfer.out_fire && !FLUSH;
            end
            default: ;
        endcase
    end

    ld_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
        .CLK  (CLK),
        .RST  (RST),
        .en_i (main_en),
        .d_i  (main_d),
        .q_o  (main_q)
    );

    ld_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
        .CLK  (CLK),
        .RST  (RST),
        .en_i (skid_en),
        .d_i  (bus.Ds),
        .q_o  (skid_q)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.Qs        = main_q;
    assign bus.count     = state_q;
endmodule

// File: tb/tb_skid_reg.sv
// Self-checking bench for skid_reg: a 2-deep queue model checked every cycle
// plus directed scenarios with literal expectations.
module tb_skid_reg;
    localparam int unsigned      WIDTH = 32;
    localparam logic [WIDTH-1:0] RV    = 32'hDEAD_BEEF;

    logic CLK, RST, FLUSH;
    int   n_pass, n_total;
    bit   cmp_en;
    logic [WIDTH-1:0] mq[$];

    skid_reg_if #(.WIDTH(WIDTH)) bus ();

    skid_reg #(.WIDTH(WIDTH), .RESET_VAL(RV)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .FLUSH (FLUSH),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Queue model: at most two words, oldest presented first.
    task automatic model_edge();
        bit in_f, out_f;
        if (RST || FLUSH) begin
            mq.delete();
        end else begin
            in_f  = bus.in_valid && (mq.size() < 2);
            out_f = (mq.size() > 0) && bus.out_ready;
            if (out_f) void'(mq.pop_front());
            if (in_f) mq.push_back(bus.Ds);
        end
    endtask

    always @(posedge CLK) model_edge();

    always @(negedge CLK) begin
        if (cmp_en) begin
            check("m_in_ready", {63'd0, bus.in_ready},
                  {63'd0, (mq.size() < 2) && !FLUSH && !RST});
            check("m_out_valid", {63'd0, bus.out_valid}, {63'd0, mq.size() > 0});
            check("m_count", {62'd0, bus.count}, 64'(mq.size()));
            if (mq.size() > 0) check("m_Qs", {32'd0, bus.Qs}, {32'd0, mq[0]});
        end
    end

    task automatic step(input logic rst, input logic fl, input logic iv,
                        input logic [WIDTH-1:0] d, input logic ordy);
        @(posedge CLK);
        #1;
        RST           = rst;
        FLUSH         = fl;
        bus.in_valid  = iv;
        bus.Ds        = d;
        bus.out_ready = ordy;
        @(negedge CLK);
    endtask

    task automatic expect_out(input string name, input logic ir, input logic ov,
                              input logic [1:0] cnt, input logic [WIDTH-1:0] q, input bit chk_q);
        check({name, "_in_ready"}, {63'd0, bus.in_ready}, {63'd0, ir});
        check({name, "_out_valid"}, {63'd0, bus.out_valid}, {63'd0, ov});
        check({name, "_count"}, {62'd0, bus.count}, {62'd0, cnt});
        if (chk_q) check({name, "_Qs"}, {32'd0, bus.Qs}, {32'd0, q});
    endtask

    initial begin
        n_pass        = 0;
        n_total       = 0;
        cmp_en        = 1'b0;
        RST           = 1'b1;
        FLUSH         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.Ds        = '0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge CLK);
        #1;
        cmp_en = 1'b1;
        @(negedge CLK);
        expect_out("reset", 1'b0, 1'b0, 2'd0, RV, 1'b1);

        // pass-through at full rate
        step(0, 0, 1, 32'd1, 1); expect_out("pt0", 1, 0, 0, '0, 0);
        step(0, 0, 1, 32'd2, 1); expect_out("pt1", 1, 1, 1, 32'd1, 1);
        step(0, 0, 1, 32'd3, 1); expect_out("pt2", 1, 1, 1, 32'd2, 1);
        step(0, 0, 1, 32'd4, 1); expect_out("pt3", 1, 1, 1, 32'd3, 1);
        step(0, 0, 0, 32'd0, 1); expect_out("pt4", 1, 1, 1, 32'd4, 1);
        step(0, 0, 0, 32'd0, 1); expect_out("pt5", 1, 0, 0, '0, 0);

        // back-pressure fills the skid, then drains in order
        step(0, 0, 1, 32'hA, 0); expect_out("bp0", 1, 0, 0, '0, 0);
        step(0, 0, 1, 32'hB, 0); expect_out("bp1", 1, 1, 1, 32'hA, 1);
        step(0, 0, 0, 32'd0, 0); expect_out("bp2", 0, 1, 2, 32'hA, 1);
        step(0, 0, 0, 32'd0, 0); expect_out("bp3", 0, 1, 2, 32'hA, 1);
        step(0, 0, 0, 32'd0, 1); expect_out("bp4", 0, 1, 2, 32'hA, 1);
        step(0, 0, 0, 32'd0, 1); expect_out("bp5", 1, 1, 1, 32'hB, 1);
        step(0, 0, 0, 32'd0, 1); expect_out("bp6", 1, 0, 0, '0, 0);

        // simultaneous push and pop while holding one word
        step(0, 0, 1, 32'd5, 0); expect_out("sp0", 1, 0, 0, '0, 0);
        step(0, 0, 1, 32'd6, 1); expect_out("sp1", 1, 1, 1, 32'd5, 1);
        step(0, 0, 1, 32'h10, 0); expect_out("sp2", 1, 1, 1, 32'd6, 1);

        // flush while full with a word offered
        step(0, 1, 1, 32'd9, 0); expect_out("fl0", 0, 1, 2, 32'd6, 1);
        step(0, 0, 0, 32'd0, 1); expect_out("fl1", 1, 0, 0, '0, 0);
        step(0, 0, 0, 32'd0, 1); expect_out("fl2", 1, 0, 0, '0, 0);

        // reset while full and the consumer is accepting
        step(0, 0, 1, 32'd7, 0); expect_out("rs0", 1, 0, 0, '0, 0);
        step(0, 0, 1, 32'd8, 0); expect_out("rs1", 1, 1, 1, 32'd7, 1);
        step(1, 0, 1, 32'h11, 1); expect_out("rs2", 0, 1, 2, 32'd7, 1);
        step(0, 0, 0, 32'd0, 1); expect_out("rs3", 1, 0, 0, RV, 1);
        step(0, 0, 0, 32'd0, 1); expect_out("rs4", 1, 0, 0, RV, 1);

        // mixed traffic checked only by the model
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
        end
        step(0, 0, 0, 32'd0, 1);
        step(0, 0, 0, 32'd0, 1);
        step(0, 0, 0, 32'd0, 1); expect_out("end", 1, 0, 0, '0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
